// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT datapath.
// - DATA_W / MAX_PTS / BUS_W: coefficient width, lanes per bus, bus width
// - size_e: 2-bit block-size code shared with the 1-D transform
// - pts_of(): points per side for a size code (4/8/16/32)
// - lane_mask(): one bit per lane, set for lanes that belong to the block
// - lane_get(): extract lane k from a [0:BUS_W-1] bus (lane 0 leftmost, MSB-first)
package dct_pkg;

  localparam int DATA_W  = 16;
  localparam int MAX_PTS = 32;
  localparam int BUS_W   = DATA_W * MAX_PTS;
  localparam int IDX_W   = $clog2(MAX_PTS);

  typedef enum logic [1:0] {
    SZ4  = 2'b00,
    SZ8  = 2'b01,
    SZ16 = 2'b10,
    SZ32 = 2'b11
  } size_e;

  typedef logic [0:BUS_W-1]  bus_t;
  typedef logic [DATA_W-1:0] coef_t;

  function automatic int pts_of(size_e s);
    return 4 << int'(s);
  endfunction

  function automatic logic [MAX_PTS-1:0] lane_mask(size_e s);
    logic [MAX_PTS-1:0] m;
    for (int k = 0; k < MAX_PTS; k++) m[k] = (k < pts_of(s));
    return m;
  endfunction

  // Ascending bus range: bit DATA_W*k is the MSB of lane k.
  function automatic coef_t lane_get(bus_t b, int k);
    return b[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/dct_tpose_mem.sv
// 32x32 coefficient store for the transpose buffer.
// - clk            : write clock
// - we / wr_row    : write one row this cycle at row index wr_row
// - wr_mask        : per-lane write enable (lanes outside the block untouched)
// - wr_data        : row bus, lane c goes to column c
// - rd_col         : column index for the read mux
// - rd_mask        : per-row enable; disabled rows read as zero
// - rd_data        : column bus, lane r = element (r, rd_col)
module dct_tpose_mem
  import dct_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_row,
  input  logic [MAX_PTS-1:0] wr_mask,
  input  bus_t               wr_data,
  input  logic [IDX_W-1:0]   rd_col,
  input  logic [MAX_PTS-1:0] rd_mask,
  output bus_t               rd_data
);

  coef_t mem [MAX_PTS][MAX_PTS];

  // NOTE: storage has no reset; every cell read in a drain was written by the
  // preceding fill, so resetting 1024 words would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < MAX_PTS; c++) begin
        if (wr_mask[c]) mem[wr_row][c] <= lane_get(wr_data, c);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < MAX_PTS; r++) begin
      if (rd_mask[r]) rd_data[r*DATA_W +: DATA_W] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Transpose buffer between the DCT row pass and column pass.
// Fills an NxN block one row per handshake, then drains it one column per
// handshake. Single bank: fill and drain never overlap.
// - clk, rst_n               : clock, asynchronous active-low reset
// - in_valid/in_ready        : row handshake (in_ready is a pure state decode)
// - in_row, in_size          : row bus, size code (sampled on row 0 only)
// - out_valid/out_ready      : column handshake
// - out_col, out_size        : column bus (lanes >= pts zero), block size code
// - out_last                 : marks the final column of a block
module dct_transpose_buffer
  import dct_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:511]   in_row,
  input  logic [1:0]     in_size,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:511]   out_col,
  output logic [1:0]     out_size,
  output logic           out_last
);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_cnt, row_d;
  logic [IDX_W-1:0] col_cnt, col_d;
  size_e            size_q, size_d;

  size_e            size_eff;
  logic             accept;
  logic             last_row;
  logic             last_col;
  logic [MAX_PTS-1:0] rd_mask;

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
      size_q  <= SZ4;
    end else begin
      state_q <= state_d;
      row_cnt <= row_d;
      col_cnt <= col_d;
      size_q  <= size_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_cnt;
    col_d     = col_cnt;
    size_d    = size_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    // The size of the row being written comes straight from the port on row 0
    // because size_q is only loaded by that very handshake.
    size_eff  = (row_cnt == '0) ? size_e'(in_size) : size_q;
    last_row  = (row_cnt == IDX_W'(pts_of(size_eff) - 1));
    last_col  = (col_cnt == IDX_W'(pts_of(size_q) - 1));

    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          size_d = size_eff;
          if (last_row) begin
            state_d = DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else begin
            row_d = row_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_col) begin
            state_d = FILL;
            col_d   = '0;
          end else begin
            col_d = col_cnt + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Row mask doubles as the output gate: all-zero outside DRAIN keeps out_col
  // at zero while filling and in reset.
  assign rd_mask  = out_valid ? lane_mask(size_q) : '0;
  assign out_last = out_valid && last_col;
  assign out_size = size_q;

  dct_tpose_mem u_mem (
    .clk     (clk),
    .we      (accept),
    .wr_row  (row_cnt),
    .wr_mask (lane_mask(size_eff)),
    .wr_data (in_row),
    .rd_col  (col_cnt),
    .rd_mask (rd_mask),
    .rd_data (out_col)
  );

endmodule

// File: tb/tb_dct_transpose_buffer.sv
module tb_dct_transpose_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:511] in_row = '0;
  logic [1:0]   in_size = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:511] out_col;
  logic [1:0]   out_size;
  logic         out_last;

  int passed = 0;
  int total  = 0;

  // Reference: the block as a plain matrix, element (row r, column c).
  logic [15:0] model [32][32];

  dct_transpose_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_size  (out_size),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic int npts(logic [1:0] s);
    return 4 << s;
  endfunction

  // Column c of the transposed block: lane r = model[r][c], lanes >= pts zero.
  function automatic logic [0:511] exp_col(int pts, int c);
    logic [0:511] b = '0;
    for (int r = 0; r < pts; r++) b[r*16 +: 16] = model[r][c];
    return b;
  endfunction

  task automatic rand_model();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) model[r][c] = 16'($urandom);
  endtask

  // Sends pts rows; row 0 carries sz, later rows carry late_sz; lanes >= pts
  // carry junk.
  task automatic fill_block(input logic [1:0] sz, input logic [1:0] late_sz,
                            input logic [15:0] junk);
    int pts = npts(sz);
    for (int r = 0; r < pts; r++) begin
      for (int c = 0; c < 32; c++) in_row[c*16 +: 16] = (c < pts) ? model[r][c] : junk;
      in_size  = (r == 0) ? sz : late_sz;
      in_valid = 1'b1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL fill_ready row %0d: in_ready=%b required 1", r, in_ready);
      else passed++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_row   = '0;
  endtask

  // Called #1 after the last row edge: first column must already be valid.
  // rst_at >= 0 pulses reset while that column is presented.
  task automatic drain_block(input logic [1:0] sz, input bit stall, input int rst_at);
    int pts = npts(sz);
    int n;
    logic [0:511] hold;
    out_ready = !stall;
    for (int c = 0; c < pts; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== '0)
          $display("FAIL async_reset: out_valid=%b in_ready=%b out_col_nonzero=%b required 0 1 0",
                   out_valid, in_ready, out_col !== '0);
        else passed++;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      total++;
      if (out_valid !== 1'b1) $display("FAIL col_valid c=%0d: out_valid=%b required 1", c, out_valid);
      else passed++;
      total++;
      if (out_col !== exp_col(pts, c))
        $display("FAIL col_data c=%0d: got %h required %h", c, out_col, exp_col(pts, c));
      else passed++;
      total++;
      if (out_last !== (c == pts - 1))
        $display("FAIL col_last c=%0d: out_last=%b required %b", c, out_last, c == pts - 1);
      else passed++;
      total++;
      if (out_size !== sz) $display("FAIL col_size c=%0d: out_size=%b required %b", c, out_size, sz);
      else passed++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL drain_ready c=%0d: in_ready=%b required 0", c, in_ready);
      else passed++;
      if (stall) begin
        n = (c == 0 || $urandom_range(0, 2) != 0) ? $urandom_range(3, 6) : 0;
        hold = out_col;
        for (int k = 0; k < n; k++) begin
          @(posedge clk); #1;
          total++;
          if (out_valid !== 1'b1 || out_col !== hold || out_last !== (c == pts - 1))
            $display("FAIL stall_hold c=%0d: valid=%b last=%b col=%h required 1 %b %h",
                     c, out_valid, out_last, out_col, c == pts - 1, hold);
          else passed++;
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (stall) out_ready = 1'b0;
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL return_fill: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_size !== 2'b00 || out_col !== '0)
      $display("FAIL reset_values: ready=%b valid=%b last=%b size=%b col_nonzero=%b required 1 0 0 00 0",
               in_ready, out_valid, out_last, out_size, out_col !== '0);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL post_reset: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_4x4();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) model[r][c] = 16'(10 * r + c);
    fill_block(2'b00, 2'b00, 16'h0000);
    drain_block(2'b00, 1'b0, -1);
  endtask

  task automatic test_32x32();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) model[r][c] = 16'((r << 5) | c);
    model[0][0]   = 16'h8000;
    model[31][31] = 16'hFFFF;
    model[5][7]   = 16'h8001;
    fill_block(2'b11, 2'b11, 16'h0000);
    drain_block(2'b11, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    rand_model();
    fill_block(2'b01, 2'b01, 16'($urandom));
    drain_block(2'b01, 1'b1, -1);
  endtask

  task automatic test_size_change();
    rand_model();
    fill_block(2'b01, 2'b11, 16'h0000);
    drain_block(2'b01, 1'b0, -1);
    rand_model();
    fill_block(2'b10, 2'b10, 16'h0000);
    drain_block(2'b10, 1'b0, -1);
  endtask

  task automatic test_garbage();
    rand_model();
    fill_block(2'b00, 2'b00, 16'h7FFF);
    drain_block(2'b00, 1'b0, -1);
  endtask

  task automatic test_reset_mid_drain();
    rand_model();
    fill_block(2'b10, 2'b10, 16'h1234);
    drain_block(2'b10, 1'b0, 5);
    rand_model();
    fill_block(2'b00, 2'b00, 16'h0000);
    drain_block(2'b00, 1'b0, -1);
  endtask

  task automatic test_random_blocks();
    logic [1:0] sz;
    for (int b = 0; b < 4; b++) begin
      sz = 2'($urandom_range(0, 3));
      rand_model();
      fill_block(sz, 2'($urandom), 16'($urandom));
      drain_block(sz, 1'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_4x4();
    test_32x32();
    test_backpressure();
    test_size_change();
    test_garbage();
    test_reset_mid_drain();
    test_random_blocks();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
